ma_stage: RTL
=============

# ma_stage

Memory-access stage of the RV32I pipeline, directly downstream of the execution stage. Consumes the EX→MA pipeline registers (load/store command, address/result, store data, width code), runs a req/ack data-memory transaction with byte-lane steering and load sign/zero extension, and produces the two write-back forwarding registers used by EX (`wbk_data_wb`, `wbk_data_wb2`). Stalls the pipeline while a memory access is outstanding, and times out hung accesses.

## Interface
- `TIMEOUT_CYC`, 255: number of WAIT cycles without `dmem_ack` before the access is abandoned; range 1..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_ld_ma`, `cmd_st_ma` in 1: load / store valid in MA.
- `rd_adr_ma` in 5, `wbk_rd_reg_ma` in 1: destination register and write enable.
- `rd_data_ma` in 32: ALU result; the effective address for loads and stores.
- `st_data_ma` in 32: store data, unaligned; the value is in the low bits.
- `ldst_code_ma` in 3: funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `stall` in 1: stall from all other sources (excludes `stall_ma`).
- `rst_pipe` in 1: synchronous pipeline flush.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_adr` out 30 [31:2], `dmem_be` out 4, `dmem_wdata` out 32: memory request.
- `dmem_ack` in 1, `dmem_rdata` in 32: memory response; `dmem_rdata` is valid only in the ack cycle.
- `stall_ma` out 1: MA access not complete this cycle. Combinational.
- `ma_misalign` out 1, `ma_bus_err` out 1: one-cycle exception pulses.
- `rd_adr_wb` out 5, `wbk_rd_reg_wb` out 1, `wbk_data_wb` out 32: MA→WB registers.
- `rd_adr_wb2` out 5, `wbk_rd_reg_wb2` out 1, `wbk_data_wb2` out 32: WB→WB2 registers, one stage later.

## Operation
- `mem_op` = `cmd_ld_ma | cmd_st_ma`.
- `misal` is true when either holds:
  - width 01 (halfword) and `adr[0]` = 1;
  - width 10 (word) and `adr[1:0]` ≠ 0.
- A misaligned op issues no request. `ma_misalign` pulses in the cycle the op leaves MA. `wbk_rd_reg_wb` is forced to 0.
- Request fields: `dmem_adr` = `rd_data_ma[31:2]`; `dmem_we` = `cmd_st_ma`.
- Byte enables:
  - SB: `4'b0001 << adr[1:0]`.
  - SH: 0011 if `adr[1]` = 0, else 1100.
  - SW: 1111.
  - Loads: 1111.
- `dmem_wdata`: SB replicates the byte ×4; SH replicates the halfword ×2; SW passes the word through. Little-endian.
- Load result: shift `dmem_rdata` right by 8×`adr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU/LW) to 32 bits.
- Non-memory ops pass `rd_data_ma` to `wbk_data_wb` unchanged. Stores write `wbk_rd_reg_wb` = 0.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, with `mem_op & ~misal`: `dmem_req` = 1.
    - `dmem_ack` = 1 and `stall` = 0: complete, WB registers load, stay in IDLE.
    - `dmem_ack` = 1 and `stall` = 1: capture the load result → HOLD.
    - `dmem_ack` = 0: → WAIT, counter = 1.
  - WAIT: `dmem_req` held with all request fields stable; the counter increments each cycle.
    - `dmem_ack` = 1: exit exactly as from IDLE.
    - counter = `TIMEOUT_CYC` with no ack: drop `dmem_req`, `ma_bus_err` = 1, load data = 0, `wbk_rd_reg_wb` = 0, exit as for ack.
  - HOLD: `dmem_req` = 0 and `stall_ma` = 0. When `stall` = 0, WB registers load from the captured data → IDLE.
- `stall_ma` = 1 in IDLE or WAIT while a request is active and there is neither ack nor timeout this cycle.
- Pipeline advance: when `stall` and `stall_ma` are both 0, MA→WB loads and WB→WB2 loads from the old WB values.
- `rst_pipe`:
  - WB and WB2 registers clear.
  - In IDLE or HOLD, go to IDLE.
  - In WAIT, keep `dmem_req` until ack or timeout (the bus cannot abort), discard the result, go to IDLE. `stall_ma` stays asserted until then.

## Timing
- Reset: all outputs 0, FSM in IDLE, counter 0.
- Zero-wait memory (ack in the request cycle): no stall; the result appears in `wbk_data_wb` the next cycle.
- N wait cycles: `stall_ma` is high for N cycles; `wbk_data_wb` updates on the edge after the ack cycle.
- `wbk_data_wb2` lags `wbk_data_wb` by exactly one advance.
- `ma_misalign` and `ma_bus_err` last one cycle and are never asserted together.
- `dmem_req` is never asserted in HOLD, for a misaligned op, or when there is no `mem_op`.
- Asynchronous `rst` during WAIT drops `dmem_req` immediately.

## Test plan
- LW `adr` = 0x100, ack in the same cycle, `rdata` = 0xDEADBEEF → no stall; next cycle `wbk_data_wb` = 0xDEADBEEF and `wbk_rd_reg_wb` = 1; one advance later `wbk_data_wb2` = 0xDEADBEEF.
- LB and LBU at `adr` = 0x103 with `rdata` = 0x80FFFFFF → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH `adr` = 0x102, `st_data` = 0x1234ABCD → `be` = 1100, `wdata` = 0xABCDABCD, `we` = 1, `wbk_rd_reg_wb` = 0.
- LW, ack after 3 cycles, with `stall` = 1 at the ack cycle for 2 more cycles → `stall_ma` high 3 cycles, HOLD for 2 cycles with `req` low, data loads when `stall` falls.
- LH `adr` = 0x101 → no `req`, `ma_misalign` one-cycle pulse, `wbk_rd_reg_wb` = 0.
- `TIMEOUT_CYC` = 4 with no ack → `req` high 5 cycles total (request cycle plus 4 WAIT), `ma_bus_err` pulse, `wbk_data_wb` = 0, `wbk_rd_reg_wb` = 0. Separately, `rst_pipe` mid-WAIT → `req` held until ack, WB registers stay 0.

Source files
------------

// File: rtl/ma_stage.sv
// ma_stage: RV32I memory-access stage with req/ack data bus, byte steering, load extension and WB/WB2 forwarding registers
module ma_stage #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] rd_data_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_adr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_ma,
  output logic        ma_misalign,
  output logic        ma_bus_err,
  output logic [4:0]  rd_adr_wb,
  output logic        wbk_rd_reg_wb,
  output logic [31:0] wbk_data_wb,
  output logic [4:0]  rd_adr_wb2,
  output logic        wbk_rd_reg_wb2,
  output logic [31:0] wbk_data_wb2
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Everything about the op in MA that must stay stable while the bus is busy
  typedef struct packed {
    logic        ld;
    logic        st;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] adr;
    logic [2:0]  code;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ma_t;

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  ma_t         req_q, req_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        hold_wen_q, hold_wen_d;
  logic [4:0]  rd_adr_wb_q, rd_adr_wb_d, rd_adr_wb2_q, rd_adr_wb2_d;
  logic        wen_wb_q, wen_wb_d, wen_wb2_q, wen_wb2_d;
  logic [31:0] data_wb_q, data_wb_d, data_wb2_q, data_wb2_d;

  logic        mem_op, misal, in_idle, in_wait, in_hold;
  logic        issue, tmo, done, flush_x, discard, wb_load;
  logic [31:0] sh, ld_val, res_data, wb_data;
  logic        res_wen, wb_wen;
  ma_t         live, cur;

  assign mem_op  = cmd_ld_ma | cmd_st_ma;
  assign misal   = mem_op & ((ldst_code_ma[1:0] == 2'b01 & rd_data_ma[0]) |
                             (ldst_code_ma[1:0] == 2'b10 & rd_data_ma[1:0] != 2'b00));
  assign in_idle = state_q == S_IDLE;
  assign in_wait = state_q == S_WAIT;
  assign in_hold = state_q == S_HOLD;

  // Decode the op currently presented by EX into bus-ready form
  always_comb begin
    live       = '0;
    live.ld    = cmd_ld_ma;
    live.st    = cmd_st_ma;
    live.rd    = rd_adr_ma;
    live.wen   = wbk_rd_reg_ma & ~cmd_st_ma & ~misal;
    live.adr   = rd_data_ma;
    live.code  = ldst_code_ma;
    live.be    = ~cmd_st_ma ? 4'hf :
                 ldst_code_ma[1:0] == 2'b00 ? 4'b0001 << rd_data_ma[1:0] :
                 ldst_code_ma[1:0] == 2'b01 ? (rd_data_ma[1] ? 4'b1100 : 4'b0011) : 4'hf;
    live.wdata = ldst_code_ma[1:0] == 2'b00 ? {4{st_data_ma[7:0]}} :
                 ldst_code_ma[1:0] == 2'b01 ? {2{st_data_ma[15:0]}} : st_data_ma;
  end

  // Issue/complete decisions, load extraction and the value headed for WB
  always_comb begin
    cur      = in_idle ? live : req_q;
    sh       = dmem_rdata >> {cur.adr[1:0], 3'b000};
    ld_val   = cur.code == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
               cur.code == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
               cur.code == 3'b100 ? {24'h0, sh[7:0]} :
               cur.code == 3'b101 ? {16'h0, sh[15:0]} : sh;
    issue    = in_idle & mem_op & ~misal & ~rst_pipe;
    tmo      = in_wait & ~dmem_ack & (cnt_q == 8'(TIMEOUT_CYC));
    done     = (issue | in_wait) & (dmem_ack | tmo);
    flush_x  = flush_q | rst_pipe;
    res_data = tmo ? 32'h0 : cur.ld ? ld_val : cur.adr;
    res_wen  = cur.wen & ~tmo;
    stall_ma = (issue | in_wait) & ~done;
    discard  = in_wait & flush_x;
    wb_load  = ~stall & ~stall_ma & ~rst_pipe & ~discard;
    wb_data  = in_hold ? hold_data_q : res_data;
    wb_wen   = in_hold ? hold_wen_q : res_wen;
  end

  // Access FSM: IDLE issues, WAIT holds the bus until ack/timeout, HOLD parks a finished result under stall
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    req_d       = req_q;
    hold_data_d = hold_data_q;
    hold_wen_d  = hold_wen_q;
    if (in_idle & issue & ~dmem_ack) begin
      state_d = S_WAIT;
      cnt_d   = 8'd1;
      req_d   = live;
    end else if (in_idle & issue & stall) begin
      state_d     = S_HOLD;
      req_d       = live;
      hold_data_d = res_data;
      hold_wen_d  = res_wen;
    end else if (in_wait & done) begin
      state_d     = (stall & ~flush_x) ? S_HOLD : S_IDLE;
      cnt_d       = 8'd0;
      flush_d     = 1'b0;
      hold_data_d = res_data;
      hold_wen_d  = res_wen;
    end else if (in_wait) begin
      cnt_d   = cnt_q + 8'd1;
      flush_d = flush_x;
    end else if (in_hold & (rst_pipe | ~stall)) begin
      state_d = S_IDLE;
    end
  end

  // Forwarding registers: flush clears both, an advance shifts WB into WB2
  always_comb begin
    rd_adr_wb_d  = rst_pipe ? 5'd0  : wb_load ? cur.rd       : rd_adr_wb_q;
    wen_wb_d     = rst_pipe ? 1'b0  : wb_load ? wb_wen       : wen_wb_q;
    data_wb_d    = rst_pipe ? 32'h0 : wb_load ? wb_data      : data_wb_q;
    rd_adr_wb2_d = rst_pipe ? 5'd0  : wb_load ? rd_adr_wb_q  : rd_adr_wb2_q;
    wen_wb2_d    = rst_pipe ? 1'b0  : wb_load ? wen_wb_q     : wen_wb2_q;
    data_wb2_d   = rst_pipe ? 32'h0 : wb_load ? data_wb_q    : data_wb2_q;
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      flush_q      <= 1'b0;
      req_q        <= '0;
      hold_data_q  <= 32'h0;
      hold_wen_q   <= 1'b0;
      rd_adr_wb_q  <= 5'd0;
      wen_wb_q     <= 1'b0;
      data_wb_q    <= 32'h0;
      rd_adr_wb2_q <= 5'd0;
      wen_wb2_q    <= 1'b0;
      data_wb2_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      req_q        <= req_d;
      hold_data_q  <= hold_data_d;
      hold_wen_q   <= hold_wen_d;
      rd_adr_wb_q  <= rd_adr_wb_d;
      wen_wb_q     <= wen_wb_d;
      data_wb_q    <= data_wb_d;
      rd_adr_wb2_q <= rd_adr_wb2_d;
      wen_wb2_q    <= wen_wb2_d;
      data_wb2_q   <= data_wb2_d;
    end
  end

  assign dmem_req       = ~rst & (issue | in_wait);
  assign dmem_we        = dmem_req & cur.st;
  assign dmem_adr       = dmem_req ? cur.adr[31:2] : 30'h0;
  assign dmem_be        = dmem_req ? cur.be : 4'h0;
  assign dmem_wdata     = dmem_req ? cur.wdata : 32'h0;
  assign ma_misalign    = in_idle & misal & ~stall & ~rst_pipe;
  assign ma_bus_err     = tmo & ~flush_x;
  assign rd_adr_wb      = rd_adr_wb_q;
  assign wbk_rd_reg_wb  = wen_wb_q;
  assign wbk_data_wb    = data_wb_q;
  assign rd_adr_wb2     = rd_adr_wb2_q;
  assign wbk_rd_reg_wb2 = wen_wb2_q;
  assign wbk_data_wb2   = data_wb2_q;
endmodule
